// File: rtl/sar_pkg.sv
// +------------------------------------------------------------------+
// | sar_pkg : shared types and defaults for the SAR search engine    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package sar_pkg;

   localparam int SAR_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } sar_state_t;

endpackage

`default_nettype wire

// File: rtl/sar_search.sv
// +------------------------------------------------------------------+
// | sar_search : MSB-first successive-approximation search driving   |
// | an external comparator. Option macro: SAR_EARLY_EXIT_EN.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sar_search
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] trial,
   input  logic             gt,
   input  logic             lt,
   input  logic             eq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_err
);

   localparam int               IW        = $clog2(WIDTH);
   localparam logic [IW-1:0]    c_IDX_MSB = IW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] c_MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_t       r_state;
   logic [WIDTH-1:0] r_trial;
   logic [WIDTH-1:0] r_result;
   logic [IW-1:0]    r_idx;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_flags_ok;
   logic [WIDTH-1:0] w_decided;
   logic [WIDTH-1:0] w_next;

   // Only lt decides the bit; the one-hot check merely flags bad comparators.
   always_comb begin
      w_flags_ok = $onehot({gt, lt, eq});
      w_decided  = r_trial;
      if (lt)
         w_decided[r_idx] = 1'b0;
      w_next = w_decided;
      if (r_idx != '0)
         w_next[r_idx - 1'b1] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_trial  <= '0;
         r_result <= '0;
         r_idx    <= c_IDX_MSB;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_trial <= c_MSB_ONE;
                  r_idx   <= c_IDX_MSB;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= SEARCH;
               end
            end
            SEARCH: begin
               if (!w_flags_ok)
                  r_err <= 1'b1;
`ifdef SAR_EARLY_EXIT_EN
               if (eq && w_flags_ok) begin
                  r_result <= r_trial;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else
`endif
               if (r_idx == '0) begin
                  r_trial  <= w_decided;
                  r_result <= w_decided;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else begin
                  r_trial <= w_next;
                  r_idx   <= r_idx - 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign trial    = r_trial;
   assign result   = r_result;
   assign busy     = r_busy;
   assign done     = r_done;
   assign flag_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// +------------------------------------------------------------------+
// | tb_sar_search : self-checking bench for sar_search with a        |
// | behavioural comparator and a bitwise reference search model.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sar_search;
   import sar_pkg::*;

   localparam int W    = SAR_DEFAULT_WIDTH;
   localparam int NOBS = 40;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         force_bad;
   logic [W-1:0] target;
   logic [W-1:0] trial;
   logic [W-1:0] result;
   logic         cmp_gt, cmp_lt, cmp_eq;
   logic         gt, lt, eq;
   logic         busy, done, flag_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] obs_trial [NOBS];
   logic [W-1:0] obs_res   [NOBS];
   logic         obs_done  [NOBS];
   logic         obs_busy  [NOBS];
   logic         obs_err   [NOBS];

   logic [W-1:0] exp_trial [W];
   logic [W-1:0] exp_res;
   int           exp_steps;

   always #5 clk = ~clk;

   sar_ref_cmp #(.WIDTH(W)) u_cmp (
      .target (target),
      .trial  (trial),
      .gt     (cmp_gt),
      .lt     (cmp_lt),
      .eq     (cmp_eq)
   );

   // force_bad corrupts the flags to gt=lt=1, eq=0
   assign gt = cmp_gt | force_bad;
   assign lt = cmp_lt | force_bad;
   assign eq = cmp_eq & ~force_bad;

   sar_search #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .trial    (trial),
      .gt       (gt),
      .lt       (lt),
      .eq       (eq),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .flag_err (flag_err)
   );

   // Binary search: keep a candidate bit whenever the target is not below the trial.
   task automatic ref_model(input logic [W-1:0] tgt, input int fstep);
      logic [W-1:0] acc;
      logic [W-1:0] t;
      acc       = '0;
      exp_steps = 0;
      for (int k = 0; k < W; k++) begin
         t            = acc | (W'(1) << (W - 1 - k));
         exp_trial[k] = t;
         exp_steps    = k + 1;
`ifdef SAR_EARLY_EXIT_EN
         if (k != fstep && t == tgt) begin
            acc = t;
            break;
         end
`endif
         if (k != fstep && tgt >= t)
            acc = t;
      end
      exp_res = acc;
   endtask

   task automatic run_obs(input logic [W-1:0] tgt, input int fc, input int sc,
                          input int rc, input int ncyc);
      target = tgt;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         obs_trial[c] = trial;
         obs_res[c]   = result;
         obs_done[c]  = done;
         obs_busy[c]  = busy;
         obs_err[c]   = flag_err;
         start        = (c == sc);
         force_bad    = (c == fc);
         rst          = (c == rc);
      end
      start     = 1'b0;
      force_bad = 1'b0;
      rst       = 1'b0;
   endtask

   function automatic int count_done(input int ncyc);
      int n = 0;
      for (int c = 1; c <= ncyc; c++)
         if (obs_done[c] === 1'b1) n++;
      return n;
   endfunction

   function automatic int first_done(input int ncyc);
      for (int c = 1; c <= ncyc; c++)
         if (obs_done[c] === 1'b1) return c;
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; force_bad = 1'b0; target = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp += 5;
      if (trial !== '0) begin n_bad++; $display("FAIL reset_trial: got %h expected 0", trial); end
      if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
      if (flag_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", flag_err); end
      rst = 1'b0;
   endtask

   task automatic test_trial_sequence();
      int d;
      ref_model(8'h5A, -1);
      run_obs(8'h5A, -1, -1, -1, 12);
      for (int k = 0; k < exp_steps; k++) begin
         n_cmp++;
         if (obs_trial[k+1] !== exp_trial[k]) begin
            n_bad++;
            $display("FAIL seq_trial[%0d]: got %h expected %h", k, obs_trial[k+1], exp_trial[k]);
         end
      end
      d = first_done(12);
      n_cmp += 4;
      if (d !== exp_steps + 1) begin n_bad++; $display("FAIL seq_done_cycle: got %0d expected %0d", d, exp_steps + 1); end
      if (d > 0 && obs_res[d] !== 8'h5A) begin n_bad++; $display("FAIL seq_result: got %h expected 5a", obs_res[d]); end
      if (obs_busy[1] !== 1'b1) begin n_bad++; $display("FAIL seq_busy_rise: got %b expected 1", obs_busy[1]); end
      if (d > 0 && obs_busy[d] !== 1'b0) begin n_bad++; $display("FAIL seq_busy_fall: got %b expected 0", obs_busy[d]); end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] tv [2];
      int d;
      tv[0] = 8'h00; tv[1] = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         ref_model(tv[i], -1);
         run_obs(tv[i], -1, -1, -1, 12);
         d = first_done(12);
         n_cmp += 3;
         if (d !== exp_steps + 1) begin n_bad++; $display("FAIL bound_done_cycle %h: got %0d expected %0d", tv[i], d, exp_steps + 1); end
         if (d > 0 && obs_res[d] !== tv[i]) begin n_bad++; $display("FAIL bound_result: got %h expected %h", obs_res[d], tv[i]); end
         if (d > 0 && obs_err[d] !== 1'b0) begin n_bad++; $display("FAIL bound_err %h: got %b expected 0", tv[i], obs_err[d]); end
      end
   endtask

   task automatic test_early_exit();
      logic [W-1:0] tv [2];
      int d;
      tv[0] = 8'h80; tv[1] = 8'h01;
      for (int i = 0; i < 2; i++) begin
         ref_model(tv[i], -1);
         run_obs(tv[i], -1, -1, -1, 12);
         d = first_done(12);
         n_cmp += 2;
         if (d !== exp_steps + 1) begin n_bad++; $display("FAIL early_done_cycle %h: got %0d expected %0d", tv[i], d, exp_steps + 1); end
         if (d > 0 && obs_res[d] !== tv[i]) begin n_bad++; $display("FAIL early_result: got %h expected %h", obs_res[d], tv[i]); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] tgt;
      int d;
      for (int i = 0; i < 16; i++) begin
         tgt = W'($urandom);
         ref_model(tgt, -1);
         run_obs(tgt, -1, -1, -1, 12);
         d = first_done(12);
         n_cmp += 3;
         if (d !== exp_steps + 1) begin n_bad++; $display("FAIL rand_done_cycle %h: got %0d expected %0d", tgt, d, exp_steps + 1); end
         if (d > 0 && obs_res[d] !== exp_res) begin n_bad++; $display("FAIL rand_result: got %h expected %h", obs_res[d], exp_res); end
         if (count_done(12) !== 1) begin n_bad++; $display("FAIL rand_done_count %h: got %0d expected 1", tgt, count_done(12)); end
      end
   endtask

   task automatic test_ignored_start();
      int d;
      ref_model(8'h33, -1);
      run_obs(8'h33, -1, 4, -1, 14);
      d = first_done(14);
      n_cmp += 3;
      if (count_done(14) !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d expected 1", count_done(14)); end
      if (d !== exp_steps + 1) begin n_bad++; $display("FAIL ign_done_cycle: got %0d expected %0d", d, exp_steps + 1); end
      if (d > 0 && obs_res[d] !== 8'h33) begin n_bad++; $display("FAIL ign_result: got %h expected 33", obs_res[d]); end
   endtask

   task automatic test_reset_mid();
      int d;
      run_obs(8'h9C, -1, -1, 5, 16);
      n_cmp += 6;
      if (obs_trial[6] !== '0) begin n_bad++; $display("FAIL rmid_trial: got %h expected 0", obs_trial[6]); end
      if (obs_res[6] !== '0) begin n_bad++; $display("FAIL rmid_result: got %h expected 0", obs_res[6]); end
      if (obs_busy[6] !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", obs_busy[6]); end
      if (obs_done[6] !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b expected 0", obs_done[6]); end
      if (obs_err[6] !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b expected 0", obs_err[6]); end
      if (count_done(16) !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d expected 0", count_done(16)); end
      ref_model(8'hC3, -1);
      run_obs(8'hC3, -1, -1, -1, 12);
      d = first_done(12);
      n_cmp += 2;
      if (d !== exp_steps + 1) begin n_bad++; $display("FAIL rmid_fresh_cycle: got %0d expected %0d", d, exp_steps + 1); end
      if (d > 0 && obs_res[d] !== 8'hC3) begin n_bad++; $display("FAIL rmid_fresh_result: got %h expected c3", obs_res[d]); end
   endtask

   task automatic test_flag_err();
      int d;
      ref_model(8'hE5, 2);
      run_obs(8'hE5, 3, -1, -1, 12);
      d = first_done(12);
      n_cmp += 6;
      if (obs_err[3] !== 1'b0) begin n_bad++; $display("FAIL ferr_before: got %b expected 0", obs_err[3]); end
      if (obs_err[4] !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b expected 1", obs_err[4]); end
      if (d !== exp_steps + 1) begin n_bad++; $display("FAIL ferr_done_cycle: got %0d expected %0d", d, exp_steps + 1); end
      if (d > 0 && obs_err[d] !== 1'b1) begin n_bad++; $display("FAIL ferr_at_done: got %b expected 1", obs_err[d]); end
      if (obs_err[12] !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b expected 1", obs_err[12]); end
      if (d > 0 && obs_res[d] !== exp_res) begin n_bad++; $display("FAIL ferr_result: got %h expected %h", obs_res[d], exp_res); end
      ref_model(8'h11, -1);
      run_obs(8'h11, -1, -1, -1, 12);
      d = first_done(12);
      n_cmp += 2;
      if (obs_err[1] !== 1'b0) begin n_bad++; $display("FAIL ferr_clear: got %b expected 0", obs_err[1]); end
      if (d > 0 && obs_res[d] !== 8'h11) begin n_bad++; $display("FAIL ferr_next_result: got %h expected 11", obs_res[d]); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] tgt;
      int d;
      tgt = W'($urandom);
      ref_model(tgt, -1);
      d = exp_steps + 1;
      run_obs(tgt, -1, d + 1, -1, 2 * d + 4);
      n_cmp += 4;
      if (count_done(2 * d + 4) !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", count_done(2 * d + 4)); end
      if (obs_busy[d + 2] !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b expected 1", obs_busy[d + 2]); end
      if (obs_done[2 * d + 1] !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done: got %b expected 1", obs_done[2 * d + 1]); end
      if (obs_res[2 * d + 1] !== exp_res) begin n_bad++; $display("FAIL b2b_result: got %h expected %h", obs_res[2 * d + 1], exp_res); end
   endtask

   initial begin
      test_reset();
      test_trial_sequence();
      test_boundaries();
      test_early_exit();
      test_random();
      test_ignored_start();
      test_reset_mid();
      test_flag_err();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// Behavioural magnitude comparator standing in for the external flag source.
module sar_ref_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] trial,
   output logic             gt,
   output logic             lt,
   output logic             eq
);
   assign gt = (target > trial);
   assign lt = (target < trial);
   assign eq = (target == trial);
endmodule

`default_nettype wire

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine that drives the trial operand of an external combinational magnitude comparator and consumes its GT/LT/EQ flags to recover an unknown target operand bit by bit, MSB first. It sits on the initiator side of the comparator interface. It returns the target value in at most WIDTH evaluation cycles, with an optional early exit on equality.

## Interface
- WIDTH, 8: operand width; legal range 2–16.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new search; sampled only in IDLE.
- trial  out  WIDTH  operand driven to the comparator's b side.
- gt  in  1  comparator flag: target > trial; combinational, same cycle as trial.
- lt  in  1  comparator flag: target < trial.
- eq  in  1  comparator flag: target == trial.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  recovered target; held until the next accepted start.
- flag_err  out  1  sticky; set if {gt,lt,eq} is not one-hot in any SEARCH cycle; cleared on an accepted start.

## Operation
- States: IDLE, SEARCH, DONE.
- Reset: state IDLE; trial=0, result=0, busy=0, done=0, flag_err=0; bit index = WIDTH-1.
- IDLE with start=1:
  - trial <= 1<<(WIDTH-1); index <= WIDTH-1; flag_err <= 0.
  - Go to SEARCH.
- SEARCH, each cycle, decides bit[index]:
  - Keep the bit if lt=0; clear it if lt=1. Only lt drives the decision.
  - If index==0: result <= decided trial; go to DONE.
  - Otherwise: set bit[index-1] in trial; index decrements.
- DONE: done=1 for exactly one cycle, then IDLE. trial holds its final value.
- Ignored requests: start in SEARCH or DONE is ignored, with no queuing.
- Non-one-hot flags (none, or more than one asserted): flag_err <= 1; the lt-only decision rule still applies.
- Reset mid-search: returns to IDLE next edge; all outputs take reset values; no done pulse is issued.
- Arithmetic: unsigned only; no carries, only bit set/clear.

## Timing
- Start sampled at edge 0 -> SEARCH on cycles 1..WIDTH -> done high on cycle WIDTH+1.
- With WIDTH=8: done on cycle 9.
- With early exit active, done comes 1 cycle after the first SEARCH cycle with eq=1. Minimum: done on cycle 2.
- busy rises the cycle after start is accepted and falls the cycle done rises.
- result updates on the edge that enters DONE, so it is valid while done=1.
- Back-to-back operation: start may be asserted the cycle after done, i.e. in IDLE. Minimum period is WIDTH+2 cycles.
- Comparator path: trial -> flags -> next-state logic is a single-cycle combinational loop through the external comparator, which must close within one clk period.

## Configuration
- SAR_EARLY_EXIT_EN defined:
  - In SEARCH, eq=1 with well-formed flags captures result <= trial and goes straight to DONE, regardless of index.
- SAR_EARLY_EXIT_EN undefined:
  - eq is used only for the flag_err check.
  - A search always takes exactly WIDTH SEARCH cycles.
- Final result is identical either way; only latency differs.

## Structure
- Package sar_pkg: state enum (IDLE, SEARCH, DONE) and default WIDTH constant.
- No RTL sub-module; the flag one-hot check is inline.
- The comparator stays external so the block can be exercised against any flag source.
- The bench instantiates a behavioural comparator, sar_ref_cmp, taking target and trial and producing gt/lt/eq.

## Test plan
- WIDTH=8, no early exit, target 0x5A, start at cycle 0 -> trial sequence 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A,0x5B; done at cycle 9; result=0x5A.
- Targets 0x00 and 0xFF -> result 0x00 / 0xFF, done at cycle 9, flag_err=0.
- SAR_EARLY_EXIT_EN, target 0x80 -> done at cycle 2, result=0x80. Target 0x01 -> done at cycle 9.
- start pulsed again at cycle 4 of a search for 0x33 -> ignored; single done at cycle 9 with result=0x33.
- rst asserted at cycle 5 of a search -> all outputs zero the next cycle; no done. A fresh start for 0xC3 -> result=0xC3.
- Bench forces gt=lt=1 at cycle 3 -> flag_err=1 sticky through done; cleared by the next accepted start.
